// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_scheduler
// Description : Round-robin scheduler that shares one registered ALU between
//               NUM_REQ valid/ready requesters, one operation at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ*2-1:0]          req_op_i,
  output logic [DATA_WIDTH-1:0]         alu_a_o,
  output logic [DATA_WIDTH-1:0]         alu_b_o,
  output logic [1:0]                    alu_op_o,
  input  logic [DATA_WIDTH-1:0]         alu_result_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [ID_W-1:0]       w_winner;
  logic [ID_W-1:0]       w_rr_next;
  logic                  w_found;
  logic                  w_accept;
  int                    w_scan_idx;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [1:0]            r_op;
  logic [ID_W-1:0]       r_id;
  logic [DATA_WIDTH-1:0] r_data;

  logic [DATA_WIDTH-1:0] w_a_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_b_arr  [NUM_REQ];
  logic [1:0]            w_op_arr [NUM_REQ];

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_a_arr[g]  = req_a_i[g*DATA_WIDTH +: DATA_WIDTH];
      assign w_b_arr[g]  = req_b_i[g*DATA_WIDTH +: DATA_WIDTH];
      assign w_op_arr[g] = req_op_i[g*2 +: 2];
    end
  endgenerate

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_scan_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_scan_idx = int'(r_rr_ptr) + i;
      if (w_scan_idx >= NUM_REQ) w_scan_idx = w_scan_idx - NUM_REQ;
      if (!w_found && req_valid_i[w_scan_idx[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_scan_idx[ID_W-1:0];
      end
    end
  end

  assign w_rr_next = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
  assign w_accept  = |(req_valid_i & req_ready_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_CAPT;
      S_CAPT:  w_next_state = S_RESP;
      S_RESP:  if (rsp_ready_i) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Ready is gated by rst_n so nothing is offered while reset is held
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = 1'b0;
    busy_o      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (rst_n && w_found) req_ready_o = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
      S_RESP:  rsp_valid_o = 1'b1;
      default: req_ready_o = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_id     <= '0;
      r_data   <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_accept) begin
        r_a      <= w_a_arr[w_winner];
        r_b      <= w_b_arr[w_winner];
        r_op     <= w_op_arr[w_winner];
        r_id     <= w_winner;
        r_rr_ptr <= w_rr_next;
      end
      if (r_state == S_CAPT) r_data <= alu_result_i;
    end
  end

  assign alu_a_o    = r_a;
  assign alu_b_o    = r_b;
  assign alu_op_o   = r_op;
  assign rsp_id_o   = r_id;
  assign rsp_data_o = r_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_rr_scheduler
// Description : Directed scoreboard bench for alu_rr_scheduler with a
//               registered ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rr_scheduler;

  localparam int DW = 32;
  localparam int NR = 4;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic [NR*2-1:0]  req_op;
  logic [DW-1:0]    alu_a, alu_b, alu_res;
  logic [1:0]       alu_op;
  logic             rsp_valid, rsp_ready, busy;
  logic [1:0]       rsp_id;
  logic [DW-1:0]    rsp_data;

  logic [DW-1:0] ta [NR];
  logic [DW-1:0] tbv [NR];
  logic [1:0]    top [NR];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb_q[$];

  alu_rr_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .alu_result_i(alu_res),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int k = 0; k < NR; k++) begin
      req_a[k*DW +: DW] = ta[k];
      req_b[k*DW +: DW] = tbv[k];
      req_op[k*2 +: 2]  = top[k];
    end
  end

  // Registered ALU: samples operands at the clock edge ending EXEC
  always @(posedge clk) begin
    case (alu_op)
      2'b00:   alu_res <= alu_a + alu_b;
      2'b01:   alu_res <= alu_a - alu_b;
      2'b10:   alu_res <= alu_a & alu_b;
      default: alu_res <= alu_a | alu_b;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: compares each completed handshake with the scoreboard
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got id %0d data %0h expected none", rsp_id, rsp_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (rsp_id !== e.id || rsp_data !== e.data) begin
          errors++;
          $display("FAIL rsp: got id %0d data %0h expected id %0d data %0h",
                   rsp_id, rsp_data, e.id, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for any grant, then checks it is the expected one-hot
  task automatic wait_grant(input int k, output int gcyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 20);
    gcyc = cyc;
    check("grant", 64'(req_ready), 64'(4'b0001 << k));
  endtask

  task automatic push(input int id, input logic [DW-1:0] d);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic set_req(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [1:0] op);
    ta[k]  = a;
    tbv[k] = b;
    top[k] = op;
  endtask

  initial begin
    int gc, last;
    // Reset with random inputs
    rst_n     = 1'b0;
    req_valid = 4'($urandom);
    rsp_ready = 1'($urandom);
    for (int k = 0; k < NR; k++) set_req(k, $urandom, $urandom, 2'($urandom));
    repeat (3) step();
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid_busy", {62'd0, rsp_valid, busy}, 64'd0);
    check("rst_alu", {alu_op, alu_a, alu_b[29:0]}, 64'd0);
    check("rst_rsp", {30'd0, rsp_id, rsp_data}, 64'd0);

    // Release with only requester 0 valid: ready in the same cycle
    step();
    set_req(0, 32'd3, 32'd4, 2'b00);
    rst_n     = 1'b1;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("release_ready", 64'(req_ready), 64'b0001);
    push(0, 32'd7);
    step();
    req_valid = '0;
    drain();

    // Single op from requester 2, latency check
    set_req(2, 32'd5, 32'd7, 2'b00);
    req_valid = 4'b0100;
    wait_grant(2, gc);
    push(2, 32'd12);
    step();
    req_valid = '0;
    @(negedge clk);
    check("exec_alu_a", 64'(alu_a), 64'd5);
    check("exec_alu_b", 64'(alu_b), 64'd7);
    @(negedge clk);
    check("t2_no_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("t3_valid", 64'(rsp_valid), 64'd1);
    drain();

    // Subtraction wrap: 0 - 1
    set_req(2, 32'd0, 32'd1, 2'b01);
    req_valid = 4'b0100;
    wait_grant(2, gc);
    push(2, 32'hFFFF_FFFF);
    step();
    req_valid = '0;
    drain();

    // rr_ptr=3, only 1 and 2 valid: 1 wins; backpressure on its AND result
    rsp_ready = 1'b0;
    set_req(1, 32'h0000_F0F0, 32'h0000_0FF0, 2'b10);
    set_req(2, 32'd9, 32'd2, 2'b11);
    req_valid = 4'b0110;
    wait_grant(1, gc);
    push(1, 32'h0000_00F0);
    step();
    req_valid = 4'b0100;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rsp_valid && n < 10);
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_hold", {rsp_valid, req_ready, rsp_id, rsp_data},
            {1'b1, 4'b0000, 2'd1, 32'h0000_00F0});
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_busy", 64'(busy), 64'd0);
    check("skip_second", 64'(req_ready), 64'b0100);
    push(2, 32'h0000_000B);
    step();
    req_valid = '0;
    drain();

    // Requester 3 op brings rr_ptr back to 0
    set_req(3, 32'd1, 32'd1, 2'b01);
    req_valid = 4'b1000;
    wait_grant(3, gc);
    push(3, 32'd0);
    step();
    req_valid = '0;
    drain();

    // Fairness: all valid, grants 0,1,2,3,0,1 spaced 4 cycles apart
    for (int k = 0; k < NR; k++) set_req(k, 32'(k + 10), 32'(k), 2'b00);
    req_valid = 4'b1111;
    last = 0;
    for (int g = 0; g < 6; g++) begin
      wait_grant(g % 4, gc);
      if (g > 0) check("grant_spacing", 64'(gc - last), 64'd4);
      last = gc;
      push(g % 4, 32'(2 * (g % 4) + 10));
      step();
      if (g == 5) req_valid = '0;
    end
    drain();

    // Reset during EXEC discards the op and clears rr_ptr
    req_valid = 4'b1111;
    wait_grant(2, gc);
    step();
    @(negedge clk);
    check("midop_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("midop_rst_out", {rsp_valid, busy, req_ready, alu_a}, 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("midop_first_grant", 64'(req_ready), 64'b0001);
    push(0, 32'd10);
    step();
    req_valid = '0;
    drain();
    repeat (8) step();
    check("no_stray_rsp", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
